// File: rtl/rob_pkg.sv
// Shared definitions for the reorder-buffer commit block.
// Holds the default buffer geometry, the architectural register file size and
// the layout of one reorder-buffer entry.
package rob_pkg;

  localparam int unsigned DEPTH         = 8;
  localparam int unsigned TAG_W         = $clog2(DEPTH);
  localparam int unsigned NUM_ARCH_REGS = 32;
  localparam int unsigned REG_W         = $clog2(NUM_ARCH_REGS);
  localparam int unsigned DATA_W        = 32;

  typedef struct packed {
    logic              busy;
    logic              ready;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit_if.sv
// Bundle of dispatch (alloc), writeback, flush and regfile-commit signals.
//   master : dispatch/execute side; drives alloc*, wb*, flush and observes
//            allocReady/allocTag/empty and the regfile write port.
//   slave  : the reorder buffer itself.
interface rob_commit_if #(
  parameter int unsigned TAG_W = rob_pkg::TAG_W
) ();
  import rob_pkg::*;

  logic              allocValid;
  logic [REG_W-1:0]  allocDest;
  logic              allocReady;
  logic [TAG_W-1:0]  allocTag;
  logic              wbValid;
  logic [TAG_W-1:0]  wbTag;
  logic [DATA_W-1:0] wbData;
  logic              flush;
  logic              ROBwriteEnable;
  logic [REG_W-1:0]  ROBwriteIndex;
  logic [DATA_W-1:0] ROBwriteData;
  logic              empty;

  modport master (
    output allocValid, allocDest, wbValid, wbTag, wbData, flush,
    input  allocReady, allocTag, ROBwriteEnable, ROBwriteIndex, ROBwriteData, empty
  );

  modport slave (
    input  allocValid, allocDest, wbValid, wbTag, wbData, flush,
    output allocReady, allocTag, ROBwriteEnable, ROBwriteIndex, ROBwriteData, empty
  );

endinterface

// File: rtl/rob_commit.sv
// Reorder buffer with in-order commit to the architectural register file.
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous active-low reset
//   io     - rob_commit_if.slave: alloc (allocValid/allocDest -> allocReady/
//            allocTag), writeback (wbValid/wbTag/wbData), flush, regfile write
//            port (ROBwriteEnable/Index/Data) and empty status.
// Entries are allocated at the tail, completed out of order by writeback and
// retired from the head. Each retirement to a non-zero register produces a
// one-cycle write strobe; a retirement is never started while a strobe is
// high, so consecutive writes are always separated by a low cycle.
module rob_commit #(
  parameter int unsigned DEPTH = rob_pkg::DEPTH,
  parameter int unsigned TAG_W = rob_pkg::TAG_W
) (
  input  logic         clk,
  input  logic         rst_n,
  rob_commit_if.slave  io
);
  import rob_pkg::*;

  rob_entry_t        rob_q [DEPTH];
  logic [TAG_W-1:0]  head_q;
  logic [TAG_W-1:0]  tail_q;
  logic [TAG_W:0]    count_q;
  logic              wen_q;
  logic [REG_W-1:0]  widx_q;
  logic [DATA_W-1:0] wdata_q;

  rob_entry_t        head_entry;
  logic              alloc_ready;
  logic              alloc_fire;
  logic              commit_fire;

  always_comb begin
    head_entry  = rob_q[head_q];
    alloc_ready = count_q < (TAG_W+1)'(DEPTH);
    alloc_fire  = io.allocValid && alloc_ready;
    commit_fire = head_entry.busy && head_entry.ready && !wen_q;
  end

  // Statement order matters: a commit clears the head after any same-cycle
  // writeback, and an alloc (always to a non-busy tail) overrides both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) rob_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      wen_q   <= 1'b0;
      widx_q  <= '0;
      wdata_q <= '0;
    end else if (io.flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rob_q[i].busy  <= 1'b0;
        rob_q[i].ready <= 1'b0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      wen_q   <= 1'b0;
    end else begin
      if (io.wbValid && rob_q[io.wbTag].busy) begin
        rob_q[io.wbTag].ready <= 1'b1;
        rob_q[io.wbTag].data  <= io.wbData;
      end

      if (commit_fire) begin
        rob_q[head_q].busy  <= 1'b0;
        rob_q[head_q].ready <= 1'b0;
        head_q              <= head_q + TAG_W'(1);
      end

      if (alloc_fire) begin
        rob_q[tail_q].busy  <= 1'b1;
        rob_q[tail_q].ready <= 1'b0;
        rob_q[tail_q].dest  <= io.allocDest;
        tail_q              <= tail_q + TAG_W'(1);
      end

      unique case ({alloc_fire, commit_fire})
        2'b10:   count_q <= count_q + (TAG_W+1)'(1);
        2'b01:   count_q <= count_q - (TAG_W+1)'(1);
        default: count_q <= count_q;
      endcase

      // Register x0 is never written; index/data hold their last value.
      wen_q <= commit_fire && (head_entry.dest != '0);
      if (commit_fire && (head_entry.dest != '0)) begin
        widx_q  <= head_entry.dest;
        wdata_q <= head_entry.data;
      end
    end
  end

  assign io.allocReady     = alloc_ready;
  assign io.allocTag       = tail_q;
  assign io.empty          = (count_q == '0);
  assign io.ROBwriteEnable = wen_q;
  assign io.ROBwriteIndex  = widx_q;
  assign io.ROBwriteData   = wdata_q;

endmodule

// File: tb/tb_rob_commit.sv
module tb_rob_commit;
  localparam int DEPTH = 8;
  localparam int TAG_W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rob_commit_if #(.TAG_W(TAG_W)) bus ();

  rob_commit #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model (queue of in-flight instructions) -----
  typedef struct {
    logic [4:0]  dest;
    bit          ready;
    logic [31:0] data;
  } ment_t;

  ment_t       mq[$];
  int          m_tail;
  bit          m_wen;
  logic [4:0]  m_idx;
  logic [31:0] m_data;

  task automatic model_reset();
    mq.delete();
    m_tail = 0;
    m_wen  = 0;
    m_idx  = '0;
    m_data = '0;
  endtask

  // Advances the model by one clock edge given the inputs applied before it.
  task automatic model_step(input bit av, input logic [4:0] ad, input bit wv,
                            input logic [2:0] wt, input logic [31:0] wd, input bit fl);
    int    sz;
    int    head;
    int    pos;
    bit    com;
    bit    acc;
    ment_t e;
    sz   = mq.size();
    head = (m_tail - sz + DEPTH) % DEPTH;
    com  = (sz > 0) && mq[0].ready && !m_wen;
    acc  = av && (sz < DEPTH);
    if (fl) begin
      mq.delete();
      m_tail = 0;
      m_wen  = 0;
      return;
    end
    if (com) e = mq[0];
    if (wv) begin
      pos = (int'(wt) - head + DEPTH) % DEPTH;
      if (pos < sz) begin
        mq[pos].ready = 1;
        mq[pos].data  = wd;
      end
    end
    m_wen = 0;
    if (com) begin
      void'(mq.pop_front());
      if (e.dest != 0) begin
        m_wen  = 1;
        m_idx  = e.dest;
        m_data = e.data;
      end
    end
    if (acc) begin
      mq.push_back('{dest: ad, ready: 0, data: '0});
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  // ---------------- write-port monitor --------------------------------
  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } wr_t;

  wr_t wlog[$];
  bit  wprev = 0;
  int  long_pulses = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      wprev = 0;
    end else begin
      if (bus.ROBwriteEnable && !wprev) wlog.push_back('{idx: bus.ROBwriteIndex, data: bus.ROBwriteData});
      if (bus.ROBwriteEnable && wprev) long_pulses++;
      wprev = bus.ROBwriteEnable;
    end
  end

  // ---------------- stimulus helpers ---------------------------------
  // Called just after a falling edge; applies inputs across the next rising
  // edge and returns at the following falling edge.
  task automatic drive(input bit av, input logic [4:0] ad, input bit wv,
                       input logic [2:0] wt, input logic [31:0] wd, input bit fl);
    bus.allocValid = av;
    bus.allocDest  = ad;
    bus.wbValid    = wv;
    bus.wbTag      = wt;
    bus.wbData     = wd;
    bus.flush      = fl;
    model_step(av, ad, wv, wt, wd, fl);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, '0, 0, '0, '0, 0);
  endtask

  task automatic do_reset();
    bus.allocValid = 0; bus.allocDest = '0; bus.wbValid = 0;
    bus.wbTag = '0; bus.wbData = '0; bus.flush = 0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #10 rst_n = 1'b1;
    @(negedge clk);
    wlog.delete();
    long_pulses = 0;
  endtask

  // ---------------- tests ---------------------------------------------
  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.allocReady !== 1'b1) begin n_err++; $display("FAIL reset_allocReady got %b want 1", bus.allocReady); end
    n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", bus.empty); end
    n_cmp++; if (bus.allocTag !== 3'd0) begin n_err++; $display("FAIL reset_allocTag got %0d want 0", bus.allocTag); end
    n_cmp++; if (bus.ROBwriteEnable !== 1'b0) begin n_err++; $display("FAIL reset_wen got %b want 0", bus.ROBwriteEnable); end
    n_cmp++; if (bus.ROBwriteIndex !== 5'd0) begin n_err++; $display("FAIL reset_widx got %0d want 0", bus.ROBwriteIndex); end
    n_cmp++; if (bus.ROBwriteData !== 32'd0) begin n_err++; $display("FAIL reset_wdata got %h want 0", bus.ROBwriteData); end
  endtask

  task automatic test_single();
    do_reset();
    drive(1, 5'd5, 0, '0, '0, 0);
    n_cmp++; if (bus.empty !== 1'b0) begin n_err++; $display("FAIL single_busy_empty got %b want 0", bus.empty); end
    drive(0, '0, 1, 3'd0, 32'h1234, 0);
    n_cmp++; if (bus.ROBwriteEnable !== 1'b0) begin n_err++; $display("FAIL single_wen_early got %b want 0", bus.ROBwriteEnable); end
    idle(1);
    n_cmp++; if (bus.ROBwriteEnable !== 1'b1) begin n_err++; $display("FAIL single_wen got %b want 1", bus.ROBwriteEnable); end
    n_cmp++; if (bus.ROBwriteIndex !== 5'd5) begin n_err++; $display("FAIL single_widx got %0d want 5", bus.ROBwriteIndex); end
    n_cmp++; if (bus.ROBwriteData !== 32'h1234) begin n_err++; $display("FAIL single_wdata got %h want 1234", bus.ROBwriteData); end
    n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL single_empty got %b want 1", bus.empty); end
    idle(1);
    n_cmp++; if (bus.ROBwriteEnable !== 1'b0) begin n_err++; $display("FAIL single_wen_fall got %b want 0", bus.ROBwriteEnable); end
    n_cmp++; if (bus.ROBwriteIndex !== 5'd5) begin n_err++; $display("FAIL single_widx_hold got %0d want 5", bus.ROBwriteIndex); end
    idle(3);
    n_cmp++; if (wlog.size() !== 1) begin n_err++; $display("FAIL single_pulses got %0d want 1", wlog.size()); end
  endtask

  task automatic test_out_of_order();
    logic [4:0]  exp_idx  [3];
    logic [31:0] exp_data [3];
    exp_idx  = '{5'd1, 5'd2, 5'd3};
    exp_data = '{32'd10, 32'd20, 32'd30};
    do_reset();
    drive(1, 5'd1, 0, '0, '0, 0);
    drive(1, 5'd2, 0, '0, '0, 0);
    drive(1, 5'd3, 0, '0, '0, 0);
    drive(0, '0, 1, 3'd2, 32'd30, 0);
    drive(0, '0, 1, 3'd0, 32'd10, 0);
    drive(0, '0, 1, 3'd1, 32'd20, 0);
    idle(10);
    n_cmp++; if (wlog.size() !== 3) begin n_err++; $display("FAIL ooo_count got %0d want 3", wlog.size()); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (i >= wlog.size()) begin
        n_err++; $display("FAIL ooo_write%0d got none want (%0d,%0d)", i, exp_idx[i], exp_data[i]);
      end else if (wlog[i].idx !== exp_idx[i] || wlog[i].data !== exp_data[i]) begin
        n_err++; $display("FAIL ooo_write%0d got (%0d,%0d) want (%0d,%0d)", i, wlog[i].idx, wlog[i].data, exp_idx[i], exp_data[i]);
      end
    end
    n_cmp++; if (long_pulses !== 0) begin n_err++; $display("FAIL ooo_pulse_width got %0d long pulses want 0", long_pulses); end
    n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL ooo_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++; if (bus.allocTag !== 3'(i)) begin n_err++; $display("FAIL full_tag%0d got %0d want %0d", i, bus.allocTag, i); end
      drive(1, 5'(i + 1), 0, '0, '0, 0);
    end
    n_cmp++; if (bus.allocReady !== 1'b0) begin n_err++; $display("FAIL full_ready got %b want 0", bus.allocReady); end
    drive(1, 5'd9, 0, '0, '0, 0);
    n_cmp++; if (bus.allocReady !== 1'b0) begin n_err++; $display("FAIL full_ignored_ready got %b want 0", bus.allocReady); end
    n_cmp++; if (bus.allocTag !== 3'd0) begin n_err++; $display("FAIL full_ignored_tag got %0d want 0", bus.allocTag); end
    drive(0, '0, 1, 3'd0, 32'hAA, 0);
    idle(1);
    n_cmp++; if (bus.ROBwriteEnable !== 1'b1 || bus.ROBwriteIndex !== 5'd1) begin n_err++; $display("FAIL full_commit got (%b,%0d) want (1,1)", bus.ROBwriteEnable, bus.ROBwriteIndex); end
    n_cmp++; if (bus.allocReady !== 1'b1) begin n_err++; $display("FAIL full_ready_after got %b want 1", bus.allocReady); end
    n_cmp++; if (bus.allocTag !== 3'd0) begin n_err++; $display("FAIL full_wrap_tag got %0d want 0", bus.allocTag); end
    drive(1, 5'd20, 0, '0, '0, 0);
    n_cmp++; if (bus.allocReady !== 1'b0 || bus.allocTag !== 3'd1) begin n_err++; $display("FAIL full_realloc got (%b,%0d) want (0,1)", bus.allocReady, bus.allocTag); end
  endtask

  task automatic test_dest_zero();
    do_reset();
    drive(1, 5'd0, 0, '0, '0, 0);
    drive(0, '0, 1, 3'd0, 32'hFFFF, 0);
    idle(4);
    n_cmp++; if (wlog.size() !== 0) begin n_err++; $display("FAIL x0_pulses got %0d want 0", wlog.size()); end
    n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL x0_empty got %b want 1", bus.empty); end
    n_cmp++; if (bus.ROBwriteData !== 32'd0) begin n_err++; $display("FAIL x0_wdata_hold got %h want 0", bus.ROBwriteData); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 5'(i + 1), 0, '0, '0, 0);
    drive(0, '0, 1, 3'd1, 32'h11, 0);
    drive(1, 5'd7, 1, 3'd0, 32'h22, 1);
    n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL flush_empty got %b want 1", bus.empty); end
    n_cmp++; if (bus.allocTag !== 3'd0) begin n_err++; $display("FAIL flush_tag got %0d want 0", bus.allocTag); end
    idle(5);
    n_cmp++; if (wlog.size() !== 0) begin n_err++; $display("FAIL flush_pulses got %0d want 0", wlog.size()); end
    n_cmp++; if (bus.allocReady !== 1'b1) begin n_err++; $display("FAIL flush_ready got %b want 1", bus.allocReady); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, 5'd7, 0, '0, '0, 0);
    drive(1, 5'd8, 0, '0, '0, 0);
    drive(0, '0, 1, 3'd0, 32'hBEEF, 0);
    idle(1);
    n_cmp++; if (bus.ROBwriteEnable !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_wen got %b want 1", bus.ROBwriteEnable); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (bus.ROBwriteEnable !== 1'b0) begin n_err++; $display("FAIL rstmid_wen got %b want 0", bus.ROBwriteEnable); end
    n_cmp++; if (bus.ROBwriteIndex !== 5'd0 || bus.ROBwriteData !== 32'd0) begin n_err++; $display("FAIL rstmid_port got (%0d,%h) want (0,0)", bus.ROBwriteIndex, bus.ROBwriteData); end
    n_cmp++; if (bus.empty !== 1'b1 || bus.allocReady !== 1'b1 || bus.allocTag !== 3'd0) begin n_err++; $display("FAIL rstmid_status got (%b,%b,%0d) want (1,1,0)", bus.empty, bus.allocReady, bus.allocTag); end
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    wlog.delete();
    idle(4);
    n_cmp++; if (wlog.size() !== 0) begin n_err++; $display("FAIL rstmid_no_strobe got %0d want 0", wlog.size()); end
  endtask

  task automatic test_random();
    bit          av, wv, fl;
    logic [4:0]  ad;
    logic [2:0]  wt;
    logic [31:0] wd;
    int          sz, head;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      n_cmp++; if (bus.allocReady !== (mq.size() < DEPTH)) begin n_err++; $display("FAIL rnd_ready c%0d got %b want %b", cyc, bus.allocReady, mq.size() < DEPTH); end
      n_cmp++; if (bus.allocTag !== 3'(m_tail)) begin n_err++; $display("FAIL rnd_tag c%0d got %0d want %0d", cyc, bus.allocTag, m_tail); end
      n_cmp++; if (bus.empty !== (mq.size() == 0)) begin n_err++; $display("FAIL rnd_empty c%0d got %b want %b", cyc, bus.empty, mq.size() == 0); end
      n_cmp++; if (bus.ROBwriteEnable !== m_wen) begin n_err++; $display("FAIL rnd_wen c%0d got %b want %b", cyc, bus.ROBwriteEnable, m_wen); end
      n_cmp++; if (bus.ROBwriteIndex !== m_idx) begin n_err++; $display("FAIL rnd_widx c%0d got %0d want %0d", cyc, bus.ROBwriteIndex, m_idx); end
      n_cmp++; if (bus.ROBwriteData !== m_data) begin n_err++; $display("FAIL rnd_wdata c%0d got %h want %h", cyc, bus.ROBwriteData, m_data); end
      sz   = mq.size();
      head = (m_tail - sz + DEPTH) % DEPTH;
      av   = ($urandom_range(0, 99) < 55);
      ad   = 5'($urandom_range(0, 31));
      wv   = ($urandom_range(0, 99) < 60);
      if (sz > 0 && $urandom_range(0, 99) < 85) wt = 3'((head + $urandom_range(0, sz - 1)) % DEPTH);
      else wt = 3'($urandom_range(0, DEPTH - 1));
      wd   = $urandom;
      fl   = ($urandom_range(0, 99) < 3);
      drive(av, ad, wv, wt, wd, fl);
    end
    n_cmp++; if (long_pulses !== 0) begin n_err++; $display("FAIL rnd_pulse_width got %0d long pulses want 0", long_pulses); end
  endtask

  initial begin
    bus.allocValid = 0; bus.allocDest = '0; bus.wbValid = 0;
    bus.wbTag = '0; bus.wbData = '0; bus.flush = 0;
    model_reset();
    test_reset();
    test_single();
    test_out_of_order();
    test_full();
    test_dest_zero();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rob_commit.md
ROB_COMMIT -- requirements
Module: rob_commit

Interface
REQ-001 Parameter DEPTH, 8, number of reorder-buffer entries (power of two).
REQ-002 Parameter TAG_W, 3, entry tag width, log2(DEPTH).
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 allocValid  in  1  dispatch requests an entry this cycle.
REQ-006 allocDest  in  5  destination architectural register of dispatched instruction.
REQ-007 allocReady  out  1  entry available (count < DEPTH).
REQ-008 allocTag  out  TAG_W  tag granted on accepted alloc (current tail).
REQ-009 wbValid  in  1  execution result writeback strobe.
REQ-010 wbTag  in  TAG_W  entry receiving the result.
REQ-011 wbData  in  32  result value.
REQ-012 flush  in  1  discard all in-flight entries.
REQ-013 ROBwriteEnable  out  1  regfile write strobe, consumed on its rising edge.
REQ-014 ROBwriteIndex  out  5  regfile register index.
REQ-015 ROBwriteData  out  32  regfile write value.
REQ-016 empty  out  1  count == 0.

Function
REQ-017 Entry fields: busy, ready, dest[4:0], data[31:0]; head, tail pointers TAG_W bits, count TAG_W+1 bits.
REQ-018 Alloc accepted when allocValid && allocReady: entry[tail] <- busy=1, ready=0, dest=allocDest; tail wraps DEPTH-1 -> 0; allocTag = tail combinationally.
REQ-019 allocValid while full: ignored, no state change.
REQ-020 wbValid to a busy entry sets ready=1, data=wbData; wbValid to a non-busy entry is ignored.
REQ-021 Commit fires at an edge where entry[head].busy && entry[head].ready (registered values) and ROBwriteEnable is currently 0: clear busy, head+1 with wrap, count-1.
REQ-022 On commit with dest != 0: ROBwriteEnable=1, ROBwriteIndex=dest, ROBwriteData=data, registered, high exactly one cycle.
REQ-023 On commit with dest == 0: entry retires, ROBwriteEnable stays 0.
REQ-024 ROBwriteEnable returns to 0 the cycle after any pulse; back-to-back commits spaced two cycles so every write yields a distinct rising edge.
REQ-025 Latency: wbValid at edge N to head -> commit at edge N+1 -> ROBwriteEnable high cycle N+1..N+2.
REQ-026 Simultaneous alloc and commit: count unchanged, both pointers advance.
REQ-027 Simultaneous wb and commit on different entries: both take effect.
REQ-028 flush highest priority: all busy/ready cleared, head=tail=count=0, ROBwriteEnable=0 next cycle; same-cycle alloc/wb/commit discarded.
REQ-029 ROBwriteIndex/ROBwriteData hold last value when ROBwriteEnable=0.

Reset
REQ-030 rst_n low asynchronously: all entries not busy/not ready, head=tail=count=0, ROBwriteEnable=0, ROBwriteIndex=0, ROBwriteData=0; thus allocReady=1, empty=1, allocTag=0.
REQ-031 Reset mid-operation discards all pending entries; no write strobe issued for them.

Structure
REQ-032 Shared package rob_pkg holds DEPTH, TAG_W, entry record layout and the architectural register count (32).
REQ-033 Single flat module; no sub-module.

Verification
REQ-034 Reset, alloc dest=5, wb tag0 data=0x1234 -> one ROBwriteEnable pulse, Index=5, Data=0x1234, empty=1 after.
REQ-035 Alloc dest 1,2,3; wb in order tag2,tag0,tag1 with data 30,10,20 -> writes in order (1,10),(2,20),(3,30), each pulse preceded by low cycle.
REQ-036 Alloc 8 entries -> allocReady=0, 9th allocValid ignored; one commit -> allocReady=1, next allocTag=0 (wrap).
REQ-037 Alloc dest=0, wb data=0xFFFF -> entry retires, ROBwriteEnable never rises, empty=1.
REQ-038 Alloc 4, wb 2, assert flush same cycle as wb tag0 -> no write strobe, empty=1, allocTag=0.
REQ-039 Assert rst_n low mid-commit pulse -> ROBwriteEnable falls immediately, all outputs at reset values.
